// File: rtl/seg_pkg.sv
// seg_pkg
// Shared definitions for the 7-segment display arbiter:
//   - arbiter FSM state enum
//   - hex-to-segment table, active-low, bit order {g,f,e,d,c,b,a}
//   - one-cold anode patterns for the four digits (digit 0 is leftmost)
//   - blank segment pattern
//   - helper that maps a digit index to its anode pattern
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW0 = 2'd1,
        SHOW1 = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_DIG0 = 4'b0111;
    localparam logic [3:0] AN_DIG1 = 4'b1011;
    localparam logic [3:0] AN_DIG2 = 4'b1101;
    localparam logic [3:0] AN_DIG3 = 4'b1110;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Indexed by the nibble value; element 0 is the glyph for 0.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    function automatic logic [3:0] an_for_digit(input logic [1:0] idx);
        logic [3:0] an;
        case (idx)
            2'd0:    an = AN_DIG0;
            2'd1:    an = AN_DIG1;
            2'd2:    an = AN_DIG2;
            default: an = AN_DIG3;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode
// Combinational hex nibble to 7-segment pattern decoder.
// Ports:
//   nib  in  4 bits : hex value to display
//   seg  out 7 bits : segments {g,f,e,d,c,b,a}, active-low
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
// Arbitrates a 4-digit 7-segment display between a high-priority alert
// requester (0) and a routine readout requester (1), and runs the
// multiplexed digit scan driving the board pins directly.
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   req0, data0  in   requester 0 request and 16-bit frame ([15:12] leftmost)
//   req1, data1  in   requester 1 request and 16-bit frame
//   gnt0, gnt1   out  ownership grants, never high together
//   busy         out  gnt0 | gnt1
//   an           out  digit anodes, active-low one-cold
//   seg          out  segments {g,f,e,d,c,b,a}, active-low
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter int SCAN_DIV    = 131072,
    parameter int HOLD_CYCLES = 100000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [15:0] data0,
    input  logic        req1,
    input  logic [15:0] data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        busy,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int HOLD_W = 27;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    state_e              state;
    state_e              state_nx;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [15:0]         frame_p0;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [1:0]          dig_idx;
    logic [3:0]          nib_sel;
    logic [6:0]          seg_dec;

    // Saturating increment: the counter parks at HOLD_MAX so the
    // pre-emption window stays open for as long as requester 1 holds on.
    function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
        return (v == HOLD_MAX) ? v : v + 1'b1;
    endfunction

    function automatic state_e next_state(
        input state_e            cur,
        input logic              r0,
        input logic              r1,
        input logic [HOLD_W-1:0] held
    );
        state_e nx;
        nx = cur;
        case (cur)
            IDLE: begin
                if (r0)      nx = SHOW0;
                else if (r1) nx = SHOW1;
            end
            SHOW0: begin
                // Requester 0 is never pre-empted; leaves only on its own drop.
                if (!r0) nx = r1 ? SHOW1 : IDLE;
            end
            SHOW1: begin
                if (!r1)                         nx = r0 ? SHOW0 : IDLE;
                else if (r0 && held == HOLD_MAX) nx = SHOW0;
            end
            default: nx = IDLE;
        endcase
        return nx;
    endfunction

    assign state_nx = next_state(state, req0, req1, hold_cnt);
    assign busy     = gnt0 | gnt1;

    // Stage p0: arbitration state, grants, hold counter and frame capture.
    // Grants are decoded from the next state so they change on the same
    // edge as the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            hold_cnt <= '0;
            frame_p0 <= '0;
        end else begin
            state <= state_nx;
            gnt0  <= (state_nx == SHOW0);
            gnt1  <= (state_nx == SHOW1);

            if (state_nx != state)
                hold_cnt <= '0;
            else if (state == SHOW1)
                hold_cnt <= sat_inc(hold_cnt);

            // Tracks live data for whichever requester owns the display next.
            if (state_nx == SHOW0)
                frame_p0 <= data0;
            else if (state_nx == SHOW1)
                frame_p0 <= data1;
        end
    end

    // Digit scan runs free of the arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            dig_idx  <= 2'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            dig_idx  <= dig_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_comb begin
        nib_sel = frame_p0[15:12];
        case (dig_idx)
            2'd0:    nib_sel = frame_p0[15:12];
            2'd1:    nib_sel = frame_p0[11:8];
            2'd2:    nib_sel = frame_p0[7:4];
            default: nib_sel = frame_p0[3:0];
        endcase
    end

    seg_hex_decode u_dec (
        .nib (nib_sel),
        .seg (seg_dec)
    );

    // Stage p1: registered pin drivers, one cycle behind frame and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else begin
            an  <= an_for_digit(dig_idx);
            seg <= (state == IDLE) ? SEG_BLANK : seg_dec;
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
module tb_seg_display_arbiter;

    localparam int SD = 4;
    localparam int HC = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [15:0] data0 = 16'h0000;
    logic [15:0] data1 = 16'h0000;
    logic        gnt0, gnt1, busy;
    logic [3:0]  an;
    logic [6:0]  seg;

    always #5 clk = ~clk;

    seg_display_arbiter #(.SCAN_DIV(SD), .HOLD_CYCLES(HC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (req0),
        .data0 (data0),
        .req1  (req1),
        .data1 (data1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .busy  (busy),
        .an    (an),
        .seg   (seg)
    );

    int checks = 0;
    int passes = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [6:0] hexseg(input int v);
        case (v)
            0: return 7'b1000000;   1: return 7'b1111001;
            2: return 7'b0100100;   3: return 7'b0110000;
            4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;
            8: return 7'b0000000;   9: return 7'b0010000;
            10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110;  13: return 7'b0100001;
            14: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // Reference model: owner 0 = nobody, 1 = requester 0, 2 = requester 1.
    // m_since counts edges requester 1 has owned the display; m_edges counts
    // edges since reset release, from which the digit position follows.
    int          m_owner, m_since, m_edges;
    logic [15:0] m_frame;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_g0, exp_g1;

    always @(posedge clk or negedge rst_n) begin
        int idx;
        int nxt;
        if (!rst_n) begin
            m_owner = 0; m_since = 0; m_edges = 0; m_frame = 16'h0;
            exp_an = 4'b1111; exp_seg = 7'b1111111; exp_g0 = 0; exp_g1 = 0;
        end else begin
            idx = (m_edges / SD) % 4;
            exp_an  = 4'b1111 ^ (4'b1000 >> idx);
            exp_seg = (m_owner == 0) ? 7'b1111111
                                     : hexseg(int'((m_frame >> (12 - 4*idx)) & 16'hF));
            nxt = m_owner;
            if (m_owner == 0)      nxt = req0 ? 1 : (req1 ? 2 : 0);
            else if (m_owner == 1) begin if (!req0) nxt = req1 ? 2 : 0; end
            else begin
                if (!req1)                     nxt = req0 ? 1 : 0;
                else if (req0 && m_since >= HC) nxt = 1;
            end
            m_since = (nxt == 2 && m_owner == 2) ? m_since + 1 : 0;
            if (nxt == 1)      m_frame = data0;
            else if (nxt == 2) m_frame = data1;
            m_owner = nxt;
            m_edges++;
            exp_g0 = (nxt == 1);
            exp_g1 = (nxt == 2);
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check("gnt0", 16'(gnt0), 16'(exp_g0));
            check("gnt1", 16'(gnt1), 16'(exp_g1));
            check("busy", 16'(busy), 16'(exp_g0 | exp_g1));
            check("an",   16'(an),   16'(exp_an));
            check("seg",  16'(seg),  16'(exp_seg));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [6:0] glyph_12af(input logic [3:0] a);
        case (a)
            4'b0111: return 7'b1111001;
            4'b1011: return 7'b0100100;
            4'b1101: return 7'b0001000;
            4'b1110: return 7'b0001110;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    initial begin
        int k;
        rst_n = 1'b0;
        cyc(3);
        check("rst_an", 16'(an), 16'hF);
        check("rst_seg", 16'(seg), 16'h7F);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Idle scan after release
        cyc(1);  check("idle_an0", 16'(an), 16'b0111); check("idle_seg", 16'(seg), 16'h7F);
        cyc(4);  check("idle_an1", 16'(an), 16'b1011);
        cyc(4);  check("idle_an2", 16'(an), 16'b1101);
        cyc(4);  check("idle_an3", 16'(an), 16'b1110); check("idle_seg3", 16'(seg), 16'h7F);

        // Asynchronous reset while granted and mid-scan
        req0 = 1'b1; data0 = 16'h1234;
        cyc(3);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_an", 16'(an), 16'hF);
        check("arst_seg", 16'(seg), 16'h7F);
        check("arst_gnt0", 16'(gnt0), 16'h0);
        check("arst_gnt1", 16'(gnt1), 16'h0);
        req0 = 1'b0;
        cyc(2);
        rst_n = 1'b1;

        // Single grant to requester 1
        req1 = 1'b1; data1 = 16'h12AF;
        cyc(1);
        check("single_gnt1", 16'(gnt1), 16'h1);
        check("single_gnt0", 16'(gnt0), 16'h0);
        for (int i = 0; i < 16; i++) begin
            cyc(1);
            check("single_seg", 16'(seg), 16'(glyph_12af(an)));
        end
        req1 = 1'b0;
        cyc(2);

        // Simultaneous requests, then handoff
        req0 = 1'b1; req1 = 1'b1; data0 = 16'h0000; data1 = 16'h5555;
        cyc(1);
        check("simul_gnt0", 16'(gnt0), 16'h1);
        check("simul_gnt1", 16'(gnt1), 16'h0);
        cyc(2);
        req0 = 1'b0;
        cyc(1);
        check("handoff_gnt0", 16'(gnt0), 16'h0);
        check("handoff_gnt1", 16'(gnt1), 16'h1);

        // Pre-emption after hold time
        cyc(2);
        req0 = 1'b1; data0 = 16'h8888;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            check("hold_gnt1", 16'(gnt1), 16'h1);
        end
        cyc(1);
        check("preempt_gnt0", 16'(gnt0), 16'h1);
        check("preempt_gnt1", 16'(gnt1), 16'h0);
        cyc(1);
        for (int i = 0; i < 8; i++) begin
            check("preempt_seg8", 16'(seg), 16'h00);
            cyc(1);
        end
        req1 = 1'b0;

        // Live data update while granted
        data0 = 16'h0000;
        cyc(2);
        data0 = 16'h000B;
        cyc(2);
        k = 0;
        while (an !== 4'b1110 && k < 12) begin cyc(1); k++; end
        check("live_an3", 16'(an), 16'b1110);
        check("live_seg_b", 16'(seg), 16'b0000011);

        // Release to idle
        req0 = 1'b0;
        cyc(1);
        check("rel_gnt0", 16'(gnt0), 16'h0);
        check("rel_busy", 16'(busy), 16'h0);
        cyc(1);
        check("rel_seg", 16'(seg), 16'h7F);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) req0 = ~req0;
            if ($urandom_range(0, 5) == 0) req1 = ~req1;
            if ($urandom_range(0, 3) == 0) data0 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) data1 = 16'($urandom);
            cyc(1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
